// File: rtl/count_pkg.sv
// Shared encodings for the counter device and its count-enable generator.
// Pure definitions: no logic, no latency, no flow control.
package count_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int DIV_DEF        = 10;

endpackage

// File: rtl/btn_debounce.sv
// Synchronise and debounce one raw button; rise is a registered one-cycle pulse.
// Raw edge to level change takes 2 + DEB_CYCLES edges; rise follows one edge later. No backpressure.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic r,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      rise     <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      rise     <= stable & ~stable_d;
      // Any bounce back to the accepted level restarts the qualification window.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/count_enable_gen.sv
// RUN/STEP button front end producing the counter's count-enable EC.
// EC and busy are registered; FSM reacts one edge after a debounced rise. No backpressure.
module count_enable_gen
  import count_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DIV        = DIV_DEF
) (
  input  logic clk,
  input  logic r,
  input  logic btn_run,
  input  logic btn_step,
  output logic EC,
  output logic busy
);

  localparam int DIV_W = $clog2(DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  state_t           state;
  state_t           next_state;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic             ec_nxt;
  logic             busy_nxt;
  logic             run_rise;
  logic             step_rise;
  logic             run_level;
  logic             step_level;
  logic             unused_levels;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clk   (clk),
    .r     (r),
    .raw   (btn_run),
    .level (run_level),
    .rise  (run_rise)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk   (clk),
    .r     (r),
    .raw   (btn_step),
    .level (step_level),
    .rise  (step_rise)
  );

  // Only edges act here; the levels are left for observation.
  assign unused_levels = run_level ^ step_level;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      EC      <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= next_state;
      div_cnt <= div_nxt;
      EC      <= ec_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (run_rise)       next_state = ST_RUN;
        else if (step_rise) next_state = ST_STEP;
        else                next_state = ST_IDLE;
      end
      ST_RUN:  next_state = run_rise ? ST_IDLE : ST_RUN;
      ST_STEP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_nxt = (next_state == ST_RUN);
    ec_nxt   = ((state == ST_RUN) && (div_cnt == DIV_LAST)) || (state == ST_STEP);
    // Prescaler restarts from zero on every RUN entry; no partial period survives.
    div_nxt  = '0;
    if ((state == ST_RUN) && (next_state == ST_RUN)) begin
      div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: tb/tb_count_enable_gen.sv
// Directed bench for count_enable_gen with DEB_CYCLES=4, DIV=10.
module tb_count_enable_gen;

  logic clk = 1'b0;
  logic r = 1'b0;
  logic btn_run = 1'b0;
  logic btn_step = 1'b0;
  logic EC;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  count_enable_gen #(.DEB_CYCLES(4), .DIV(10)) dut (
    .clk      (clk),
    .r        (r),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .EC       (EC),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Clean RUN press used only to leave RUN between scenarios.
  task automatic toggle_run_clean();
    btn_run = 1'b1;
    repeat (10) next_edge();
    btn_run = 1'b0;
    repeat (20) next_edge();
  endtask

  task automatic test_reset();
    #1 r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      btn_run  = ~btn_run;
      btn_step = ~btn_step;
      n_checks++;
      if (EC !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold t=%0t EC=%b busy=%b expected 0/0", $time, EC, busy);
      end
    end
    btn_run  = 1'b0;
    btn_step = 1'b0;
    r = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      next_edge();
      n_checks++;
      if (EC !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release edge=%0d EC=%b busy=%b expected 0/0", k, EC, busy);
      end
    end
  endtask

  task automatic test_run_start();
    logic [3:0] q;
    logic exp_ec;
    q = 4'd0;
    btn_run = 1'b1;
    for (int k = 1; k <= 43; k++) begin
      next_edge();
      exp_ec = (k > 8) && ((k - 8) % 10 == 0);
      n_checks++;
      if (busy !== (k >= 8)) begin
        n_fail++;
        $display("FAIL run_start_busy edge=%0d busy=%b expected %b", k, busy, (k >= 8));
      end
      n_checks++;
      if (EC !== exp_ec) begin
        n_fail++;
        $display("FAIL run_start_ec edge=%0d EC=%b expected %b", k, EC, exp_ec);
      end
      if (EC === 1'b1) q = q + 4'd1;
      if (k == 10) btn_run = 1'b0;
    end
    n_checks++;
    if (q !== 4'd3) begin
      n_fail++;
      $display("FAIL run_start_q q=%0d expected 3", q);
    end
  endtask

  task automatic test_run_stop();
    btn_run = 1'b1;
    for (int k = 1; k <= 58; k++) begin
      next_edge();
      n_checks++;
      if (busy !== (k <= 7)) begin
        n_fail++;
        $display("FAIL run_stop_busy edge=%0d busy=%b expected %b", k, busy, (k <= 7));
      end
      if (k >= 9) begin
        n_checks++;
        if (EC !== 1'b0) begin
          n_fail++;
          $display("FAIL run_stop_ec edge=%0d EC=%b expected 0", k, EC);
        end
      end
      if (k == 10) btn_run = 1'b0;
    end
  endtask

  task automatic test_bounce();
    int rises;
    logic prev_busy;
    rises = 0;
    prev_busy = busy;
    for (int k = 1; k <= 40; k++) begin
      btn_run = (k <= 20) ? (((k - 1) / 2) % 2 == 0) : 1'b1;
      next_edge();
      n_checks++;
      if (busy !== (k >= 28)) begin
        n_fail++;
        $display("FAIL bounce_busy edge=%0d busy=%b expected %b", k, busy, (k >= 28));
      end
      if (busy === 1'b1 && prev_busy === 1'b0) rises++;
      prev_busy = busy;
    end
    n_checks++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL bounce_entries count=%0d expected 1", rises);
    end
    btn_run = 1'b0;
    repeat (20) next_edge();
    toggle_run_clean();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_exit busy=%b expected 0", busy);
    end
  endtask

  task automatic test_step();
    int pulses;
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      btn_step = 1'b1;
      for (int k = 1; k <= 20; k++) begin
        next_edge();
        n_checks++;
        if (EC !== (k == 9) || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL step_idle press=%0d edge=%0d EC=%b busy=%b expected %b/0",
                   p, k, EC, busy, (k == 9));
        end
        if (EC === 1'b1) pulses++;
        if (k == 8) btn_step = 1'b0;
      end
    end
    n_checks++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL step_count pulses=%0d expected 3", pulses);
    end
  endtask

  task automatic test_step_during_run();
    logic exp_ec;
    btn_run = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      next_edge();
      exp_ec = (k > 8) && ((k - 8) % 10 == 0);
      n_checks++;
      if (busy !== (k >= 8) || EC !== exp_ec) begin
        n_fail++;
        $display("FAIL step_in_run edge=%0d EC=%b busy=%b expected %b/%b",
                 k, EC, busy, exp_ec, (k >= 8));
      end
      if (k == 10) btn_run = 1'b0;
      if (k == 25) btn_step = 1'b1;
      if (k == 33) btn_step = 1'b0;
    end
    toggle_run_clean();
    n_checks++;
    if (busy !== 1'b0 || EC !== 1'b0) begin
      n_fail++;
      $display("FAIL step_in_run_exit EC=%b busy=%b expected 0/0", EC, busy);
    end
  endtask

  task automatic test_simultaneous_and_reset();
    btn_run  = 1'b1;
    btn_step = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      next_edge();
      n_checks++;
      if (busy !== (k >= 8) || EC !== (k == 18)) begin
        n_fail++;
        $display("FAIL simultaneous edge=%0d EC=%b busy=%b expected %b/%b",
                 k, EC, busy, (k == 18), (k >= 8));
      end
      if (k == 10) begin
        btn_run  = 1'b0;
        btn_step = 1'b0;
      end
    end
    #2 r = 1'b1;
    #1;
    n_checks++;
    if (EC !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run EC=%b busy=%b expected 0/0", EC, busy);
    end
    #4 r = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      next_edge();
      n_checks++;
      if (EC !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL after_reset edge=%0d EC=%b busy=%b expected 0/0", k, EC, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_start();
    test_run_stop();
    test_bounce();
    test_step();
    test_step_during_run();
    test_simultaneous_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
